// File: rtl/data_memory_block.sv
// Block-organised main data memory behind the data cache.
// Serves whole 128-bit line reads (refills) and writes (write-backs) over a
// level-sensitive request / busywait handshake with a fixed access latency.
//
// Parameters:
//   DEPTH   - number of 128-bit blocks (power of two, >= 2)
//   LATENCY - BUSY cycles per access (>= 1)
// Ports:
//   clock          - rising-edge clock
//   RESET          - synchronous, active-high reset; also clears the whole array
//   mem_read       - block read request (level, held until busywait falls)
//   mem_write      - block write request (level, wins over mem_read)
//   mem_block_addr - block address, only the low log2(DEPTH) bits are used
//   mem_writedata  - block to store
//   mem_readdata   - registered block read result, held until the next read
//   mem_busywait   - combinational stall, low only in DONE or with no request
module data_memory_block #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 5
) (
    input  logic         clock,
    input  logic         RESET,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_block_addr,
    input  logic [127:0] mem_writedata,
    output logic [127:0] mem_readdata,
    output logic         mem_busywait
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter only has to hold LATENCY-1.
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CntLoad = CW'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [127:0]    data_q, data_d;
    logic            is_write_q, is_write_d;
    logic            access;

    logic [127:0]    mem [DEPTH];

    // Upper address bits alias onto the same blocks.
    logic unused_addr;
    assign unused_addr = ^mem_block_addr[27:AW];

    assign access       = (state_q == StBusy) && (cnt_q == '0);
    assign mem_busywait = (mem_read | mem_write) & (state_q != StDone);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        is_write_d = is_write_q;
        unique case (state_q)
            StIdle: begin
                if (mem_write) begin
                    state_d    = StBusy;
                    cnt_d      = CntLoad;
                    addr_d     = mem_block_addr[AW-1:0];
                    data_d     = mem_writedata;
                    is_write_d = 1'b1;
                end else if (mem_read) begin
                    state_d    = StBusy;
                    cnt_d      = CntLoad;
                    addr_d     = mem_block_addr[AW-1:0];
                    is_write_d = 1'b0;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            // A request still held here is picked up again from IDLE.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            is_write_q <= is_write_d;
        end
    end

    // Reset clears every block, so an in-flight write is lost.
    always_ff @(posedge clock) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (access && is_write_q) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            mem_readdata <= '0;
        end else if (access && !is_write_q) begin
            mem_readdata <= mem[addr_q];
        end
    end

endmodule

// File: tb/tb_data_memory_block.sv
// Self-checking bench for data_memory_block: one instance at LATENCY=5 and one
// at LATENCY=1, each compared every cycle against a transaction-level model.
module tb_data_memory_block;

    logic         clock = 1'b0;
    logic         RESET;
    logic         rd    [2];
    logic         wr    [2];
    logic [27:0]  addr  [2];
    logic [127:0] wd    [2];
    logic [127:0] rdat  [2];
    logic         bw    [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_memory_block #(.DEPTH(256), .LATENCY(5)) u_dut0 (
        .clock          (clock),
        .RESET          (RESET),
        .mem_read       (rd[0]),
        .mem_write      (wr[0]),
        .mem_block_addr (addr[0]),
        .mem_writedata  (wd[0]),
        .mem_readdata   (rdat[0]),
        .mem_busywait   (bw[0])
    );

    data_memory_block #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clock          (clock),
        .RESET          (RESET),
        .mem_read       (rd[1]),
        .mem_write      (wr[1]),
        .mem_block_addr (addr[1]),
        .mem_writedata  (wd[1]),
        .mem_readdata   (rdat[1]),
        .mem_busywait   (bw[1])
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic int lat_of(input int k);
        return (k == 0) ? 5 : 1;
    endfunction

    logic [127:0] m_mem  [2][256];
    logic [127:0] m_rd   [2];
    int           m_left [2] = '{-1, -1};  // edges left until the array access
    bit           m_done [2] = '{0, 0};    // the cycle after the access edge
    bit           m_wr   [2];
    logic [7:0]   m_addr [2];
    logic [127:0] m_data [2];
    bit           started = 0;

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (RESET) begin
                for (int i = 0; i < 256; i++) m_mem[k][i] = '0;
                m_rd[k]   = '0;
                m_left[k] = -1;
                m_done[k] = 0;
            end else if (m_done[k]) begin
                m_done[k] = 0;
            end else if (m_left[k] < 0) begin
                if (wr[k] || rd[k]) begin
                    m_wr[k]   = wr[k];
                    m_addr[k] = addr[k][7:0];
                    m_data[k] = wd[k];
                    m_left[k] = lat_of(k);
                end
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    if (m_wr[k]) m_mem[k][m_addr[k]] = m_data[k];
                    else         m_rd[k] = m_mem[k][m_addr[k]];
                    m_done[k] = 1;
                    m_left[k] = -1;
                end
            end
        end
        if (RESET) started = 1;
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busywait dut%0d t=%0t", k, $time), 128'(bw[k]),
                      128'((rd[k] | wr[k]) & !m_done[k]));
                check($sformatf("readdata dut%0d t=%0t", k, $time), rdat[k], m_rd[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input int k, output int busy, output logic [127:0] data);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bw[k]) busy++;
            else break;
        end
        if (bw[k]) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: busywait still %b, required 0", k, bw[k]);
        end
        data = rdat[k];
    endtask

    task automatic access(input int k, input bit r, input bit w, input logic [27:0] a,
                          input logic [127:0] d, output int busy, output logic [127:0] data);
        @(posedge clock); #1;
        rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
        wait_done(k, busy, data);
        @(posedge clock); #1;
        rd[k] = 0; wr[k] = 0;
    endtask

    localparam logic [127:0] PatP = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PatA = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    localparam logic [127:0] PatB = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] PatC = 128'hC0FFEE00_12345678_DEADBEEF_CAFEF00D;
    localparam logic [127:0] PatD = 128'hDDDD0000_DDDD1111_DDDD2222_DDDD3333;

    initial begin
        int           busy;
        logic [127:0] data;

        RESET = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 0; wr[k] = 0; addr[k] = '0; wd[k] = '0;
        end
        repeat (2) @(posedge clock);
        #1 RESET = 1'b0;
        @(negedge clock);
        check("reset readdata", rdat[0], '0);
        check("reset busywait", 128'(bw[0]), '0);

        // Read of a freshly cleared block.
        access(0, 1, 0, 28'h3, '0, busy, data);
        check("read 0x3 busy cycles", 128'(busy), 128'(6));
        check("read 0x3 data", data, '0);

        // Write then read back; write must not disturb readdata.
        access(0, 0, 1, 28'h10, PatP, busy, data);
        check("write 0x10 busy cycles", 128'(busy), 128'(6));
        check("write 0x10 readdata unchanged", data, '0);
        access(0, 1, 0, 28'h10, '0, busy, data);
        check("read 0x10 data", data, PatP);

        // Read held continuously through DONE.
        access(0, 0, 1, 28'h05, PatA, busy, data);
        @(posedge clock); #1;
        rd[0] = 1; addr[0] = 28'h05;
        wait_done(0, busy, data);
        check("held read busy cycles", 128'(busy), 128'(6));
        check("held read data", data, PatA);
        @(negedge clock);
        check("busywait re-rise after DONE", 128'(bw[0]), 128'(1));
        @(posedge clock); #1;
        rd[0] = 0;
        repeat (8) @(posedge clock);
        #1;

        // Simultaneous read and write: write wins.
        access(0, 1, 1, 28'h07, PatB, busy, data);
        check("rd+wr busy cycles", 128'(busy), 128'(6));
        check("rd+wr readdata unchanged", data, PatA);
        access(0, 1, 0, 28'h07, '0, busy, data);
        check("read 0x07 data", data, PatB);

        // Reset during a write: the write is lost and the array is cleared.
        @(posedge clock); #1;
        wr[0] = 1; addr[0] = 28'h02; wd[0] = PatD;
        repeat (2) @(posedge clock);
        #1;
        wr[0] = 0; RESET = 1'b1;
        @(posedge clock); #1;
        RESET = 1'b0;
        check("readdata after mid reset", rdat[0], '0);
        access(0, 1, 0, 28'h02, '0, busy, data);
        check("read 0x02 after reset", data, '0);
        access(0, 1, 0, 28'h10, '0, busy, data);
        check("read 0x10 cleared", data, '0);

        // LATENCY=1 instance: aliasing and two-cycle completion.
        access(1, 0, 1, 28'h0000105, PatC, busy, data);
        check("lat1 write busy cycles", 128'(busy), 128'(2));
        access(1, 1, 0, 28'h0000005, '0, busy, data);
        check("lat1 read busy cycles", 128'(busy), 128'(2));
        check("lat1 aliased read data", data, PatC);

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

endmodule
